gcd_stream: RTL

- Parametrised, streaming successor of the 4-bit GCD processor: computes GCD(a, b) of two WIDTH-bit unsigned operands by Euclidean subtraction with swap.
- Operands enter and results leave through valid/ready handshakes.
- Each result carries the iteration count. The result is held under back-pressure, and a synchronous abort cancels an in-flight computation.
- Sits between an operand producer and a result consumer. It replaces the req/busy/valid pairing with standard flow control.

---
 rtl/gcd_pkg.sv | 25 ++
 rtl/gcd_stream_if.sv | 30 +++
 rtl/gcd_datapath.sv | 42 ++++
 rtl/gcd_stream.sv | 103 ++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the streaming GCD block.
package gcd_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Operation the controller asks the A/B datapath to perform this cycle.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_SWAP,
    OP_SUB
  } dp_op_t;

  // Step-counter width. The worst case is 2^width steps (2^width-1 subtracts
  // plus one swap), so one extra bit is enough.
  function automatic int calc_stepw(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/gcd_stream_if.sv
// Operand/result handshake bundle for gcd_stream.
// slave = the GCD block; master = the producer/consumer side.
interface gcd_stream_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int STEPW = calc_stepw(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic [STEPW-1:0] out_steps;

  modport slave (
    input  in_valid, in_a, in_b, abort, out_ready,
    output in_ready, out_valid, out_gcd, out_steps
  );

  modport master (
    output in_valid, in_a, in_b, abort, out_ready,
    input  in_ready, out_valid, out_gcd, out_steps
  );

endinterface

// File: rtl/gcd_datapath.sv
// A/B operand registers with load / swap / subtract update and the two
// comparator flags the controller needs. Pure data: no reset, since the
// controller always loads both registers before reading the flags.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  dp_op_t           i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_a,
  output logic             o_a_lt,
  output logic             o_b_zero
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Apply the operation selected by the controller; A >= B whenever OP_SUB is
  // chosen, so the subtraction never wraps.
  always_ff @(posedge clk) begin
    case (i_op)
      OP_LOAD: begin
        r_a <= i_a;
        r_b <= i_b;
      end
      OP_SWAP: begin
        r_a <= r_b;
        r_b <= r_a;
      end
      OP_SUB:  r_a <= r_a - r_b;
      default: ;
    endcase
  end

  assign o_a      = r_a;
  assign o_a_lt   = (r_a < r_b);
  assign o_b_zero = (r_b == '0);

endmodule

// File: rtl/gcd_stream.sv
// Streaming GCD by Euclidean subtraction with swap. Controller, step counter,
// result register and valid/ready handshakes live here; the A/B arithmetic is
// in gcd_datapath.
module gcd_stream
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  gcd_stream_if.slave  bus
);

  localparam int STEPW = calc_stepw(WIDTH);

  state_t           r_state;
  logic [STEPW-1:0] r_steps;
  logic [WIDTH-1:0] r_gcd;
  logic             r_out_valid;

  dp_op_t           w_op;
  logic [WIDTH-1:0] w_a;
  logic             w_a_lt;
  logic             w_b_zero;
  logic             w_in_fire;
  logic             w_out_fire;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STEPW-1:0] sat_inc(input logic [STEPW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign bus.in_ready   = (r_state == IDLE) && !bus.abort;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_gcd    = r_gcd;
  assign bus.out_steps  = r_steps;

  assign w_in_fire  = bus.in_valid && bus.in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  gcd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .i_op     (w_op),
    .i_a      (bus.in_a),
    .i_b      (bus.in_b),
    .o_a      (w_a),
    .o_a_lt   (w_a_lt),
    .o_b_zero (w_b_zero)
  );

  // Pick this cycle's datapath operation; an aborted CALC cycle leaves A/B alone.
  always_comb begin
    w_op = OP_HOLD;
    case (r_state)
      IDLE: if (w_in_fire) w_op = OP_LOAD;
      CALC: if (!bus.abort && !w_b_zero) w_op = w_a_lt ? OP_SWAP : OP_SUB;
      default: w_op = OP_HOLD;
    endcase
  end

  // Controller with registered outputs. out_valid rises one cycle after
  // entering DONE, giving the accept-to-valid latency of steps + 2 edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_steps     <= '0;
      r_gcd       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_steps <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (bus.abort) begin
            r_state <= IDLE;
          end else if (w_b_zero) begin
            r_gcd   <= w_a;
            r_state <= DONE;
          end else begin
            r_steps <= sat_inc(r_steps);
          end
        end
        DONE: begin
          if (bus.abort || w_out_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule
